// File: rtl/serial_pattern_detector_pkg.sv
// Shared constants and state encoding for the serial pattern detector lab blocks.
package serial_pattern_detector_pkg;

  localparam int unsigned DEF_N       = 4;
  localparam logic [3:0]  DEF_PATTERN = 4'b1011;
  localparam int unsigned DEF_CW      = 8;

  // FILL until the first full window of valid bits is in, RUN afterwards.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag; reusable by other lab blocks.
module sat_counter
  import serial_pattern_detector_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          sat
);

  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] count_q, count_d;
  logic          sat_q, sat_d;

  // Next count: clear wins, otherwise increment until all-ones and latch the flag.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else begin
      if (inc && (count_q != MAX)) begin
        count_d = count_q + CW'(1);
      end
      sat_d = sat_q | (count_d == MAX);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Detects a fixed N-bit pattern (overlapping) in a gated serial stream and counts matches.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int unsigned  N       = DEF_N,
  parameter logic [N-1:0] PATTERN = N'(DEF_PATTERN),
  parameter int unsigned  CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          din,
  input  logic          din_valid,
  output logic          match,
  output logic [CW-1:0] match_count,
  output logic          count_sat,
  output logic          window_full
);

  localparam int unsigned   FW        = $clog2(N);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  window_q, window_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          match_q, match_d;
  logic [N-1:0]  window_shift_c;
  logic          last_fill_c;

  // Window as it would look after accepting the current bit; MSB is the oldest bit.
  assign window_shift_c = {window_q[N-2:0], din};
  assign last_fill_c    = (fill_q == FILL_LAST);

  // Next-state logic: shifter, fill counter, FILL/RUN FSM and pattern compare.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    if (clear) begin
      state_d  = ST_FILL;
      window_d = '0;
      fill_d   = '0;
    end else if (din_valid) begin
      window_d = window_shift_c;
      // The Nth bit may complete a pattern, so compare while it is being accepted.
      match_d  = (window_shift_c == PATTERN) && ((state_q == ST_RUN) || last_fill_c);
      if (state_q == ST_FILL) begin
        if (last_fill_c) begin
          state_d = ST_RUN;
        end else begin
          fill_d = fill_q + FW'(1);
        end
      end
    end
  end

  // State, window, fill counter and match pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FILL;
      window_q <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
    end
  end

  // Match counter advances on the same edge the match pulse is raised.
  sat_counter #(
    .CW(CW)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .inc  (match_d),
    .count(match_count),
    .sat  (count_sat)
  );

  assign match       = match_q;
  assign window_full = (state_q == ST_RUN);

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Randomised and directed bench for serial_pattern_detector against a bit-history model.
module tb_serial_pattern_detector;

  localparam int         N    = 4;
  localparam int         CW   = 8;
  localparam logic [3:0] PAT  = 4'b1011;
  localparam int         MAXC = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic          count_sat;
  logic          window_full;
  logic [CW+2:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // Model state: accepted bits since reset/clear (last N kept), last pulse, count.
  bit   hist[$];
  logic m_match = 1'b0;
  int   m_count = 0;

  serial_pattern_detector #(
    .N(N), .PATTERN(PAT), .CW(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .match      (match),
    .match_count(match_count),
    .count_sat  (count_sat),
    .window_full(window_full)
  );

  assign dut_vec = {match, match_count, count_sat, window_full};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic void model_reset();
    hist.delete();
    m_match = 1'b0;
    m_count = 0;
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_edge();
    if (!reset || clear) begin
      model_reset();
    end else if (din_valid) begin
      hist.push_back(din);
      if (hist.size() > N) void'(hist.pop_front());
      m_match = (hist.size() == N);
      for (int i = 0; i < hist.size(); i++) begin
        if (hist[i] != PAT[N-1-i]) m_match = 1'b0;
      end
      if (m_match && (m_count < MAXC)) m_count++;
    end else begin
      m_match = 1'b0;
    end
  endfunction

  function automatic logic [CW+2:0] exp_vec();
    return {m_match, CW'(m_count), (m_count == MAXC), (hist.size() == N)};
  endfunction

  task automatic step(input logic d, input logic v, input logic c);
    din       = d;
    din_valid = v;
    clear     = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0);
      total++;
      if (dut_vec !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=0", i, dut_vec);
      end
    end
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (dut_vec !== '0 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_release got=%b exp=0", dut_vec);
    end
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL basic bit=%0d got=%b exp=%b", 3 - i, dut_vec, exp_vec());
      end
      total++;
      if (i > 0 && (match !== 1'b0 || window_full !== 1'b0)) begin
        bad++;
        $display("FAIL basic_early bit=%0d match=%b full=%b exp 0/0", 3 - i, match, window_full);
      end else if (i == 0 && (match !== 1'b1 || match_count !== 8'd1 || window_full !== 1'b1)) begin
        bad++;
        $display("FAIL basic_hit match=%b count=%0d full=%b exp 1/1/1", match, match_count, window_full);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    total++;
    if (match !== 1'b0 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL basic_idle match=%b count=%0d exp 0/1", match, match_count);
    end
  endtask

  task automatic test_gap();
    logic [6:0] bits = 7'b1011011;
    int pulses = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      if (i == 1) begin
        for (int g = 0; g < 2; g++) begin
          step(1'($urandom), 1'b0, 1'b0);
          total++;
          if (dut_vec !== exp_vec() || match !== 1'b0) begin
            bad++;
            $display("FAIL gap_idle got=%b exp=%b", dut_vec, exp_vec());
          end
        end
      end
      step(bits[i], 1'b1, 1'b0);
      if (match === 1'b1) pulses++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL gap bit=%0d got=%b exp=%b", 6 - i, dut_vec, exp_vec());
      end
    end
    total++;
    if (pulses != 2 || match_count !== 8'd2) begin
      bad++;
      $display("FAIL gap_total pulses=%0d count=%0d exp 2/2", pulses, match_count);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] bits = 4'b1011;
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 260; k++) begin
      for (int i = 3; i >= 0; i--) begin
        step(bits[i], 1'b1, 1'b0);
        total++;
        if (dut_vec !== exp_vec()) begin
          bad++;
          $display("FAIL sat k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
        end
      end
      if (k == 254 || k == 255 || k == 260) begin
        total++;
        if (match !== 1'b1 || count_sat !== (k >= 255) ||
            match_count !== CW'((k >= 255) ? 255 : k)) begin
          bad++;
          $display("FAIL sat_point k=%0d match=%b count=%0d sat=%b", k, match, match_count, count_sat);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] bits = 4'b1011;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL clear_drop got=%b exp=0", dut_vec);
    end
    for (int i = 3; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL clear_after got=%b exp=%b", dut_vec, exp_vec());
      end
    end
    total++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL clear_match match=%b count=%0d exp 1/1", match, match_count);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] bits = 7'b0111011;
    int pulses = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=0", dut_vec);
    end
    #2 reset = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      if (match === 1'b1) pulses++;
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL async_after bit=%0d got=%b exp=%b", 6 - i, dut_vec, exp_vec());
      end
    end
    total++;
    if (pulses != 1 || match_count !== 8'd1) begin
      bad++;
      $display("FAIL async_total pulses=%0d count=%0d exp 1/1", pulses, match_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_saturation();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
